// File: rtl/sin_dds_gen_if.sv
// rtl/sin_dds_gen_if.sv - control and sample bus of the DDS waveform generator
// Master drives tuning/strobe inputs; slave (the generator) returns the samples.
interface sin_dds_gen_if #(
  parameter int OUT_W   = 8,
  parameter int PHASE_W = 16
);
  logic               sample_clk;
  logic               enable;
  logic [PHASE_W-1:0] phase_inc;
  logic               phase_inc_ld;
  logic [1:0]         mode;
  logic [OUT_W-1:0]   out;
  logic               new_period;
  logic               start_conv;
  logic               halfcycle;

  modport master (
    output sample_clk, enable, phase_inc, phase_inc_ld, mode,
    input  out, new_period, start_conv, halfcycle
  );

  modport slave (
    input  sample_clk, enable, phase_inc, phase_inc_ld, mode,
    output out, new_period, start_conv, halfcycle
  );
endinterface

// File: rtl/sin_dds_gen.sv
// rtl/sin_dds_gen.sv - phase-accumulator waveform generator with ADC trigger
// Sine uses a quarter-wave table built at elaboration; other modes decode the phase.
module sin_dds_gen #(
  parameter int OUT_W    = 8,
  parameter int PHASE_W  = 16,
  parameter int LUT_AW   = 6,
  parameter int CONV_DIV = 8,
  parameter int INC_RST  = 256
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  sin_dds_gen_if.slave  bus
);

  localparam int LUT_N = 1 << LUT_AW;
  localparam int SC_W  = $clog2(CONV_DIV);
  localparam logic [OUT_W-1:0] MID = OUT_W'(1) << (OUT_W - 1);
  localparam longint PI_FX = 64'sd3373259426;

  // Fixed-point (2^-30) Taylor series of sin over the first quadrant, rounded.
  function automatic logic [OUT_W-1:0] q_entry(input int i);
    longint x, x2, term, sum, amp;
    x    = (PI_FX * longint'(2 * i + 1)) >>> (LUT_AW + 2);
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int k = 1; k <= 7; k++) begin
      term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    amp = longint'((1 << (OUT_W - 1)) - 1);
    return OUT_W'((sum * amp + (longint'(1) << 29)) >>> 30);
  endfunction

  logic [OUT_W-1:0] lut [LUT_N];
  for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
    localparam logic [OUT_W-1:0] QV = q_entry(gi);
    assign lut[gi] = QV;
  end

  logic               sample_p_q;
  logic [PHASE_W-1:0] acc_q, inc_q, acc_d;
  logic [SC_W-1:0]    sc_q, sc_d;
  logic               pend_q, wrap_q, conv_q, wrap_d, upd;
  logic [OUT_W-1:0]   out_q, wave_d;
  logic               new_period_q, start_conv_q, half_q;

  logic [1:0]         quad;
  logic [LUT_AW-1:0]  addr, idx;
  logic [OUT_W-1:0]   qv;
  logic [OUT_W:0]     tri_p;

  always_comb begin
    upd              = bus.sample_clk & ~sample_p_q & bus.enable;
    {wrap_d, acc_d}  = {1'b0, acc_q} + {1'b0, inc_q};
    sc_d             = (wrap_d || sc_q == SC_W'(CONV_DIV - 1)) ? '0 : sc_q + 1'b1;
  end

  // Decoded from the accumulator already advanced one cycle earlier.
  always_comb begin
    quad   = acc_q[PHASE_W-1 -: 2];
    addr   = acc_q[PHASE_W-3 -: LUT_AW];
    idx    = quad[0] ? ~addr : addr;
    qv     = lut[idx];
    tri_p  = acc_q[PHASE_W-1 -: OUT_W+1];
    wave_d = MID;
    case (bus.mode)
      2'd0: wave_d = quad[1] ? (MID - OUT_W'(1) - qv) : (MID + qv);
      2'd1: wave_d = tri_p[OUT_W] ? ~tri_p[OUT_W-1:0] : tri_p[OUT_W-1:0];
      2'd2: wave_d = {OUT_W{~acc_q[PHASE_W-1]}};
      default: wave_d = acc_q[PHASE_W-1 -: OUT_W];
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sample_p_q   <= 1'b0;
      acc_q        <= '0;
      inc_q        <= PHASE_W'(INC_RST);
      sc_q         <= '0;
      pend_q       <= 1'b0;
      wrap_q       <= 1'b0;
      conv_q       <= 1'b0;
      out_q        <= MID;
      new_period_q <= 1'b0;
      start_conv_q <= 1'b0;
      half_q       <= 1'b0;
    end else begin
      sample_p_q <= bus.sample_clk;
      if (bus.phase_inc_ld) inc_q <= bus.phase_inc;
      pend_q <= upd;
      if (upd) begin
        acc_q  <= acc_d;
        sc_q   <= sc_d;
        wrap_q <= wrap_d;
        conv_q <= (sc_d == '0);
      end
      new_period_q <= pend_q & wrap_q;
      start_conv_q <= pend_q & conv_q;
      if (pend_q) begin
        out_q  <= wave_d;
        half_q <= ~acc_q[PHASE_W-1];
      end
    end
  end

  assign bus.out        = out_q;
  assign bus.new_period = new_period_q;
  assign bus.start_conv = start_conv_q;
  assign bus.halfcycle  = half_q;

endmodule

// File: tb/tb_sin_dds_gen.sv
// tb/tb_sin_dds_gen.sv - scoreboard bench for sin_dds_gen
// Stimulus pushes predicted samples; a negedge monitor pops and compares them.
module tb_sin_dds_gen;
  localparam int OUT_W    = 8;
  localparam int PHASE_W  = 16;
  localparam int LUT_AW   = 6;
  localparam int CONV_DIV = 8;
  localparam int INC_RST  = 256;
  localparam int MID      = 1 << (OUT_W - 1);
  localparam int PMOD     = 1 << PHASE_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sin_dds_gen_if #(.OUT_W(OUT_W), .PHASE_W(PHASE_W)) bus ();

  sin_dds_gen #(
    .OUT_W(OUT_W), .PHASE_W(PHASE_W), .LUT_AW(LUT_AW),
    .CONV_DIV(CONV_DIV), .INC_RST(INC_RST)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  int hold_val = MID * 16;
  int m_acc = 0;
  int m_inc = INC_RST;
  int m_sc = 0;
  int np_cnt = 0;
  int sc_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
  endtask

  function automatic int ref_wave(input int acc, input int md);
    int nl, amp, quarter, quad, pos, i, qv, p;
    nl = 1 << LUT_AW;
    amp = MID - 1;
    case (md)
      0: begin
        quarter = 1 << (PHASE_W - 2);
        quad = acc / quarter;
        pos = (acc % quarter) / (1 << (PHASE_W - 2 - LUT_AW));
        i = (quad == 0 || quad == 2) ? pos : nl - 1 - pos;
        qv = $rtoi(amp * $sin(3.141592653589793 * (i + 0.5) / (2.0 * nl)) + 0.5);
        return (quad < 2) ? MID + qv : MID - 1 - qv;
      end
      1: begin
        p = acc / (1 << (PHASE_W - OUT_W - 1));
        return (p >= (1 << OUT_W)) ? (1 << (OUT_W + 1)) - 1 - p : p;
      end
      2: return (acc < PMOD / 2) ? (1 << OUT_W) - 1 : 0;
      default: return acc / (1 << (PHASE_W - OUT_W));
    endcase
  endfunction

  function automatic int pack_dut();
    return int'(bus.out) * 16 + (bus.halfcycle ? 4 : 0)
         + (bus.new_period ? 2 : 0) + (bus.start_conv ? 1 : 0);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      np_cnt += bus.new_period ? 1 : 0;
      sc_cnt += bus.start_conv ? 1 : 0;
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        exp_t e;
        e = sb.pop_front();
        check("sample", pack_dut(), e.val);
        hold_val = e.val & ~3;
      end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
        exp_t e;
        e = sb.pop_front();
        check("sample_missed", pack_dut(), e.val);
      end else begin
        check("idle_hold", pack_dut(), hold_val);
      end
    end
  end

  task automatic do_edge(input bit en, input int md, input bit ld, input int inc,
                         input int high, input int low);
    int nacc;
    bit wrap;
    exp_t e;
    @(posedge clk); #1;
    bus.sample_clk = 1'b1;
    bus.enable = en;
    bus.mode = 2'(md);
    bus.phase_inc_ld = ld;
    bus.phase_inc = PHASE_W'(inc);
    if (en) begin
      nacc = m_acc + m_inc;
      wrap = (nacc >= PMOD);
      nacc = nacc % PMOD;
      m_sc = (wrap || m_sc == CONV_DIV - 1) ? 0 : m_sc + 1;
      e.cyc = cyc + 2;
      e.val = ref_wave(nacc, md) * 16 + ((nacc < PMOD / 2) ? 4 : 0)
            + (wrap ? 2 : 0) + ((m_sc == 0) ? 1 : 0);
      sb.push_back(e);
      m_acc = nacc;
    end
    if (ld) m_inc = inc;
    for (int k = 0; k < high + low - 1; k++) begin
      @(posedge clk); #1;
      bus.phase_inc_ld = 1'b0;
      if (k == high - 1) bus.sample_clk = 1'b0;
    end
  endtask

  task automatic load_inc(input int inc);
    @(posedge clk); #1;
    bus.phase_inc_ld = 1'b1;
    bus.phase_inc = PHASE_W'(inc);
    m_inc = inc;
    @(posedge clk); #1;
    bus.phase_inc_ld = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 20) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() > 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic do_reset(input bit with_edge);
    drain();
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.sample_clk = with_edge;
    bus.enable = 1'b1;
    m_acc = 0;
    m_sc = 0;
    m_inc = INC_RST;
    hold_val = MID * 16;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.sample_clk = 1'b0;
  endtask

  task automatic check_now(input string name, input int act_sel, input int exp);
    @(negedge clk);
    check(name, (act_sel == 0) ? int'(bus.out) : int'(bus.halfcycle), exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int np0, sc0, md, inc;
    bit en, ld;
    int mode_exp[3];
    int mode_sel[3];
    bus.sample_clk = 1'b0;
    bus.enable = 1'b1;
    bus.phase_inc = '0;
    bus.phase_inc_ld = 1'b0;
    bus.mode = 2'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_out", int'(bus.out), MID);
    check("reset_flags", pack_dut() % 16, 0);

    np0 = np_cnt;
    sc0 = sc_cnt;
    for (int e = 1; e <= 256; e++) begin
      do_edge(1'b1, 0, 1'b0, 0, 1, 1);
      if (e == 1) begin
        drain();
        check_now("edge1_out", 0, 133);
        check_now("edge1_half", 1, 1);
      end
      if (e == 128) begin
        drain();
        check_now("edge128_out", 0, 125);
        check_now("edge128_half", 1, 0);
      end
    end
    drain();
    check_now("edge256_out", 0, 130);
    check("period_conv_count", sc_cnt - sc0, 32);
    check("period_np_count", np_cnt - np0, 1);

    mode_sel[0] = 2; mode_exp[0] = 255;
    mode_sel[1] = 3; mode_exp[1] = 1;
    mode_sel[2] = 1; mode_exp[2] = 2;
    for (int m = 0; m < 3; m++) begin
      do_reset(1'b0);
      do_edge(1'b1, mode_sel[m], 1'b0, 0, 1, 1);
      drain();
      check_now("mode_first_out", 0, mode_exp[m]);
    end

    do_reset(1'b0);
    np0 = np_cnt;
    do_edge(1'b1, 0, 1'b1, 'h4000, 1, 1);
    for (int e = 0; e < 5; e++) do_edge(1'b1, 0, 1'b0, 0, 1, 1);
    drain();
    check("inc_load_np_count", np_cnt - np0, 1);

    np0 = np_cnt;
    sc0 = sc_cnt;
    for (int e = 0; e < 5; e++) do_edge(1'b0, 0, 1'b0, 0, 1, 1);
    drain();
    check("disabled_strobes", (np_cnt - np0) + (sc_cnt - sc0), 0);
    do_edge(1'b1, 0, 1'b0, 0, 1, 1);
    drain();

    load_inc(0);
    np0 = np_cnt;
    sc0 = sc_cnt;
    for (int e = 0; e < 24; e++) do_edge(1'b1, 3, 1'b0, 0, 1, 1);
    drain();
    check("zero_inc_conv_count", sc_cnt - sc0, 3);
    check("zero_inc_np_count", np_cnt - np0, 0);

    load_inc(INC_RST);
    for (int n = 0; n < 400; n++) begin
      en = ($urandom_range(0, 9) != 0);
      md = $urandom_range(0, 3);
      ld = ($urandom_range(0, 9) == 0);
      inc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, PMOD - 1);
      do_edge(en, md, ld, inc, $urandom_range(1, 2), $urandom_range(1, 2));
    end
    drain();

    do_reset(1'b0);
    for (int e = 0; e < 99; e++) do_edge(1'b1, 0, 1'b0, 0, 1, 1);
    do_reset(1'b1);
    check_now("midreset_out", 0, MID);
    do_edge(1'b1, 0, 1'b0, 0, 1, 1);
    drain();
    check_now("midreset_next_out", 0, 133);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
